// File: rtl/id_ex_register.sv
// ID/EX pipeline register.
//
// Captures the decode-stage controls, datapath values and register specifiers
// for one clock, so the execute stage sees them exactly one cycle later.
// Edge priority is flush, then stall, then load. A bubble, from a flush or from
// a load of an empty ID slot, always carries all-zero controls. bubble_count
// counts loaded bubbles and saturates at 16'hFFFF.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   stall, flush           hold everything / load a bubble
//   in_valid, ctl_in       ID slot valid flag and gated decode controls
//   pc_plus4_in .. imm_in  DATA_WIDTH datapath values
//   rs_in, rt_in, rd_in    register specifiers
//   *_out                  registered copies of the above
//   out_valid              EX slot holds a real instruction
//   bubble_count           saturating count of bubbles loaded since reset
module id_ex_register #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [8:0]                ctl_in,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_in,
    input  logic [DATA_WIDTH-1:0]     rd_data1_in,
    input  logic [DATA_WIDTH-1:0]     rd_data2_in,
    input  logic [DATA_WIDTH-1:0]     imm_in,
    input  logic [REG_ADDR_WIDTH-1:0] rs_in,
    input  logic [REG_ADDR_WIDTH-1:0] rt_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    output logic [8:0]                ctl_out,
    output logic [DATA_WIDTH-1:0]     pc_plus4_out,
    output logic [DATA_WIDTH-1:0]     rd_data1_out,
    output logic [DATA_WIDTH-1:0]     rd_data2_out,
    output logic [DATA_WIDTH-1:0]     imm_out,
    output logic [REG_ADDR_WIDTH-1:0] rs_out,
    output logic [REG_ADDR_WIDTH-1:0] rt_out,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic                      out_valid,
    output logic [15:0]               bubble_count
);

    logic [8:0]                ctl_q, ctl_d;
    logic                      valid_q, valid_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d;
    logic [DATA_WIDTH-1:0]     rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      bubble_load;

    // A bubble enters on a flush, or on a plain load of an empty ID slot.
    assign bubble_load = flush | (~stall & ~in_valid);

    always_comb begin
        ctl_d   = ctl_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        if (flush) begin
            // Datapath is deliberately held; only the controls are killed.
            ctl_d   = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            ctl_d   = in_valid ? ctl_in : 9'd0;
            valid_d = in_valid;
            pc_d    = pc_plus4_in;
            rd1_d   = rd_data1_in;
            rd2_d   = rd_data2_in;
            imm_d   = imm_in;
            rs_d    = rs_in;
            rt_d    = rt_in;
            rd_d    = rd_in;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bubble_load && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            ctl_q   <= ctl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    assign ctl_out      = ctl_q;
    assign out_valid    = valid_q;
    assign bubble_count = cnt_q;
    assign pc_plus4_out = pc_q;
    assign rd_data1_out = rd1_q;
    assign rd_data2_out = rd2_q;
    assign imm_out      = imm_q;
    assign rs_out       = rs_q;
    assign rt_out       = rt_q;
    assign rd_out       = rd_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized self-checking bench for id_ex_register against a behavioural
// model of the ID/EX stage.
module tb_id_ex_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, in_valid;
    logic [8:0]  ctl_in;
    logic [31:0] pc_plus4_in, rd_data1_in, rd_data2_in, imm_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic [8:0]  ctl_out;
    logic [31:0] pc_plus4_out, rd_data1_out, rd_data2_out, imm_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic        out_valid;
    logic [15:0] bubble_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the EX slot should hold.
    logic [8:0]  exp_ctl;
    logic        exp_valid;
    int          exp_cnt;
    logic [31:0] exp_pc, exp_r1, exp_r2, exp_imm;
    logic [4:0]  exp_rs, exp_rt, exp_rd;

    id_ex_register #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .ctl_in      (ctl_in),
        .pc_plus4_in (pc_plus4_in),
        .rd_data1_in (rd_data1_in),
        .rd_data2_in (rd_data2_in),
        .imm_in      (imm_in),
        .rs_in       (rs_in),
        .rt_in       (rt_in),
        .rd_in       (rd_in),
        .ctl_out     (ctl_out),
        .pc_plus4_out(pc_plus4_out),
        .rd_data1_out(rd_data1_out),
        .rd_data2_out(rd_data2_out),
        .imm_out     (imm_out),
        .rs_out      (rs_out),
        .rt_out      (rt_out),
        .rd_out      (rd_out),
        .out_valid   (out_valid),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".ctl"},   64'(ctl_out),      64'(exp_ctl));
        check_eq({tag, ".valid"}, 64'(out_valid),    64'(exp_valid));
        check_eq({tag, ".cnt"},   64'(bubble_count), 64'(exp_cnt));
        check_eq({tag, ".pc"},    64'(pc_plus4_out), 64'(exp_pc));
        check_eq({tag, ".r1"},    64'(rd_data1_out), 64'(exp_r1));
        check_eq({tag, ".r2"},    64'(rd_data2_out), 64'(exp_r2));
        check_eq({tag, ".imm"},   64'(imm_out),      64'(exp_imm));
        check_eq({tag, ".rs"},    64'(rs_out),       64'(exp_rs));
        check_eq({tag, ".rt"},    64'(rt_out),       64'(exp_rt));
        check_eq({tag, ".rd"},    64'(rd_out),       64'(exp_rd));
    endtask

    task automatic model_reset();
        exp_ctl = '0; exp_valid = 1'b0; exp_cnt = 0;
        exp_pc = '0; exp_r1 = '0; exp_r2 = '0; exp_imm = '0;
        exp_rs = '0; exp_rt = '0; exp_rd = '0;
    endtask

    // What one clock edge does to the EX slot, given the current inputs.
    task automatic model_edge();
        if (flush) begin
            exp_ctl   = '0;
            exp_valid = 1'b0;
            exp_cnt   = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
        end else if (!stall) begin
            exp_valid = in_valid;
            exp_ctl   = in_valid ? ctl_in : 9'd0;
            exp_pc = pc_plus4_in; exp_r1 = rd_data1_in; exp_r2 = rd_data2_in;
            exp_imm = imm_in; exp_rs = rs_in; exp_rt = rt_in; exp_rd = rd_in;
            if (!in_valid) exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
        end
    endtask

    task automatic rand_data();
        ctl_in      = 9'($urandom);
        pc_plus4_in = $urandom;
        rd_data1_in = $urandom;
        rd_data2_in = $urandom;
        imm_in      = $urandom;
        rs_in       = 5'($urandom);
        rt_in       = 5'($urandom);
        rd_in       = 5'($urandom);
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step(input string tag, input bit do_check);
        model_edge();
        @(posedge clk);
        #1;
        if (do_check) check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        rand_data();
        model_reset();
        #2;
        check_all("reset");
        #10 rst_n = 1'b1;   // released between edges
        @(posedge clk); #1;
        // Edge in that window saw reset still asserted? No: release at t=12, edge at 15.
        // The edge at 15 was a normal load with in_valid=0.
        model_edge();
        check_all("first_edge");

        // Directed load of a real instruction.
        in_valid = 1'b1; ctl_in = 9'h1A5; rd_data1_in = 32'hDEADBEEF;
        step("load_1a5", 1'b1);

        // Stall for three cycles while inputs move.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_data(); in_valid = 1'($urandom);
            step("stall3", 1'b1);
        end

        // Flush and stall together: bubble wins, datapath held.
        flush = 1'b1; stall = 1'b1; ctl_in = 9'h1FF; in_valid = 1'b1; rand_data(); ctl_in = 9'h1FF;
        step("flush_stall", 1'b1);
        flush = 1'b0; stall = 1'b0;

        // Empty ID slot with all controls set.
        in_valid = 1'b0; ctl_in = 9'h1FF;
        step("load_invalid", 1'b1);

        // Stall while already holding a bubble: no count.
        stall = 1'b1;
        step("stall_on_bubble", 1'b1);
        stall = 1'b0;

        // Random traffic; mid-cycle input changes must not reach the outputs.
        for (int i = 0; i < 400; i++) begin
            flush    = ($urandom_range(0, 9) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            rand_data();
            step("rand", 1'b1);
            #2;
            rand_data(); flush = 1'($urandom); stall = 1'($urandom); in_valid = 1'($urandom);
            #1;
            check_eq("no_comb.ctl", 64'(ctl_out), 64'(exp_ctl));
            check_eq("no_comb.r1", 64'(rd_data1_out), 64'(exp_r1));
            check_eq("no_comb.valid", 64'(out_valid), 64'(exp_valid));
            flush    = ($urandom_range(0, 9) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            rand_data();
        end

        // Reset asserted between edges during a stall.
        flush = 1'b0; stall = 1'b0; in_valid = 1'b1; rand_data();
        step("pre_rst_load", 1'b1);
        stall = 1'b1;
        step("pre_rst_stall", 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk); #1 rst_n = 1'b1;
        stall = 1'b0; in_valid = 1'b1; rand_data();
        step("post_rst_load", 1'b1);

        // Saturation of the bubble counter.
        flush = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            rand_data();
            step("sat", 1'b0);
        end
        check_all("sat_reached");
        check_eq("sat_value", 64'(bubble_count), 64'hFFFF);
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step("sat_hold", 1'b1);
        end
        flush = 1'b0; in_valid = 1'b0;
        step("sat_hold_load", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
